// File: rtl/prach_c_plane_mc.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// prach_c_plane_mc
// Multi-channel PRACH C-Plane decoder. Accepts one parsed eCPRI/xRAN
// C-Plane section per avst_sink_c_valid strobe, keeps UL section-type-3
// messages with the configured filterIndex, maps the RTC ID to a channel
// through a programmable table, computes frequency/time offsets plus the
// U-Plane header, and queues the result in a first-word-fall-through FIFO.
//
// Pipeline: stage 1 input register -> stage 2 classify/lookup/compute
// register -> stage 3 FIFO write. Strobe in cycle 0 shows m_valid in cycle 3.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   avst_sink_c_valid     one-cycle strobe per section
//   rx_c_*                parsed header / section fields
//   cfg_we/addr/en/rtc_id channel table write port (addr >= NUM_CH ignored)
//   stat_clr              clears drop/nomatch counters and overflow flag
//   m_valid/m_ready       command handshake, m_* stable while stalled
//   m_chan ... m_header   decoded command fields
//   drop_count            saturating count of commands lost on a full FIFO
//   nomatch_count         saturating count of PRACH messages with no channel
//   overflow              sticky, set on any drop
//
// Optional build macro PRACH_C_PLANE_SEQ_CHECK_EN adds seq_err_count, a
// saturating count of per-channel sequence-number discontinuities.
// ---------------------------------------------------------------------------
module prach_c_plane_mc #(
    parameter int NUM_CC       = 3,
    parameter int NUM_ANT      = 8,
    parameter int QUEUE_DEPTH  = 4,
    parameter int FILTER_INDEX = 1,
    parameter int FREQ_BIAS    = 864,
    localparam int NUM_CH      = NUM_CC * NUM_ANT,
    localparam int CH_W        = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              avst_sink_c_valid,
    input  logic [15:0]       rx_c_rtc_id,
    input  logic [15:0]       rx_c_seq_id,
    input  logic              rx_c_dataDirection,
    input  logic [2:0]        rx_c_payloadVersion,
    input  logic [3:0]        rx_c_filterIndex,
    input  logic [7:0]        rx_c_frameId,
    input  logic [3:0]        rx_c_subframeId,
    input  logic [5:0]        rx_c_slotId,
    input  logic [5:0]        rx_c_symbolId,
    input  logic [7:0]        rx_c_sectionType,
    input  logic [15:0]       rx_c_timeOffset,
    input  logic [15:0]       rx_c_cpLength,
    input  logic [7:0]        rx_c_udCompHdr,
    input  logic [11:0]       rx_c_sectionId,
    input  logic              rx_c_rb,
    input  logic              rx_c_symInc,
    input  logic [9:0]        rx_c_startPrbc,
    input  logic [7:0]        rx_c_numPrbc,
    input  logic [3:0]        rx_c_numSymbol,
    input  logic [23:0]       rx_c_freqOffset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_addr,
    input  logic              cfg_en,
    input  logic [15:0]       cfg_rtc_id,
    input  logic              stat_clr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_chan,
    output logic [16:0]       m_frequency_offset,
    output logic [19:0]       m_time_offset,
    output logic [3:0]        m_num_symbol,
    output logic [119:0]      m_header,
    output logic [15:0]       drop_count,
    output logic [15:0]       nomatch_count,
    output logic              overflow
`ifdef PRACH_C_PLANE_SEQ_CHECK_EN
    ,
    output logic [15:0]       seq_err_count
`endif
);

    localparam int AW = $clog2(QUEUE_DEPTH);

    typedef struct packed {
        logic [15:0] rtc_id;
        logic        dir;
        logic [2:0]  pv;
        logic [3:0]  filt;
        logic [7:0]  frame;
        logic [3:0]  subframe;
        logic [5:0]  slot;
        logic [5:0]  symbol;
        logic [7:0]  stype;
        logic [15:0] time_off;
        logic [15:0] cp_len;
        logic [7:0]  udc;
        logic [11:0] sect_id;
        logic        rb;
        logic        sym_inc;
        logic [9:0]  start_prbc;
        logic [7:0]  num_prbc;
        logic [3:0]  num_sym;
        logic [23:0] freq_off;
    } s1_t;

    typedef struct packed {
        logic [CH_W-1:0] chan;
        logic [16:0]     freq;
        logic [19:0]     tim;
        logic [3:0]      nsym;
        logic [119:0]    hdr;
    } cmd_t;

    // ---------------- stage 1: input register ----------------
    logic v1;
    s1_t  s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else begin
            v1 <= avst_sink_c_valid;
            if (avst_sink_c_valid) begin
                s1 <= '{rtc_id: rx_c_rtc_id, dir: rx_c_dataDirection,
                        pv: rx_c_payloadVersion, filt: rx_c_filterIndex,
                        frame: rx_c_frameId, subframe: rx_c_subframeId,
                        slot: rx_c_slotId, symbol: rx_c_symbolId,
                        stype: rx_c_sectionType, time_off: rx_c_timeOffset,
                        cp_len: rx_c_cpLength, udc: rx_c_udCompHdr,
                        sect_id: rx_c_sectionId, rb: rx_c_rb,
                        sym_inc: rx_c_symInc, start_prbc: rx_c_startPrbc,
                        num_prbc: rx_c_numPrbc, num_sym: rx_c_numSymbol,
                        freq_off: rx_c_freqOffset};
            end
        end
    end

    // ---------------- channel table ----------------
    logic [15:0]       tbl_rtc [NUM_CH];
    logic [NUM_CH-1:0] tbl_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                tbl_rtc[k] <= {4'h0, 4'((k % NUM_ANT) / 4), 4'(k / NUM_ANT),
                               4'((k % NUM_ANT) % 4)};
            end
            tbl_en <= '1;
        end else if (cfg_we && (32'(cfg_addr) < 32'(NUM_CH))) begin
            tbl_rtc[cfg_addr] <= cfg_rtc_id;
            tbl_en[cfg_addr]  <= cfg_en;
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    logic            hit;
    logic [CH_W-1:0] hit_idx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (tbl_en[k] && (tbl_rtc[k] == s1.rtc_id)) begin
                hit     = 1'b1;
                hit_idx = CH_W'(k);
            end
        end
    end

    // ---------------- stage 2: classify and compute ----------------
    logic prach_c;
    cmd_t cmd_c;

    always_comb begin
        prach_c = v1 && (s1.dir == 1'b0) && (s1.filt == 4'(FILTER_INDEX)) &&
                  (s1.stype == 8'd3);
        cmd_c      = '0;
        cmd_c.chan = hit_idx;
        cmd_c.freq = 17'(32'd0 - 32'($signed(s1.freq_off)) - 32'(FREQ_BIAS));
        // (symbolId+6)/7 counts the long-CP symbols already passed in the slot
        cmd_c.tim  = 20'(32'(s1.subframe) * 32'd61440 +
                         32'(s1.symbol) * 32'd4384 +
                         ((32'(s1.symbol) + 32'd6) / 32'd7) * 32'd32 +
                         32'(s1.time_off) * 32'd2 +
                         32'(s1.cp_len) * 32'd2);
        cmd_c.nsym = s1.num_sym;
        cmd_c.hdr  = {16'b0, s1.rtc_id, 16'b0, s1.dir, s1.pv, s1.filt,
                      s1.frame, s1.subframe, s1.slot, s1.symbol, s1.sect_id,
                      s1.rb, s1.sym_inc, s1.start_prbc, s1.num_prbc, s1.udc};
    end

    logic v2_prach;
    logic v2_hit;
    cmd_t s2_cmd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_prach <= 1'b0;
            v2_hit   <= 1'b0;
            s2_cmd   <= '0;
        end else begin
            v2_prach <= prach_c;
            v2_hit   <= hit;
            s2_cmd   <= cmd_c;
        end
    end

    // ---------------- stage 3: FIFO ----------------
    cmd_t          fifo_mem [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop_ev;
    logic          nomatch_ev;

    assign m_valid    = (count != '0);
    assign full       = (count == (AW + 1)'(QUEUE_DEPTH));
    assign pop        = m_valid && m_ready;
    assign push_req   = v2_prach && v2_hit;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = push_req && (!full || pop);
    assign drop_ev    = push_req && full && !pop;
    assign nomatch_ev = v2_prach && !v2_hit;

    assign {m_chan, m_frequency_offset, m_time_offset, m_num_symbol, m_header} =
        fifo_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < QUEUE_DEPTH; k++) begin
                fifo_mem[k] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= s2_cmd;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count    <= '0;
            nomatch_count <= '0;
            overflow      <= 1'b0;
        end else if (stat_clr) begin
            drop_count    <= '0;
            nomatch_count <= '0;
            overflow      <= 1'b0;
        end else begin
            if (drop_ev) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            if (nomatch_ev && (nomatch_count != 16'hFFFF)) begin
                nomatch_count <= nomatch_count + 16'd1;
            end
        end
    end

`ifdef PRACH_C_PLANE_SEQ_CHECK_EN
    // ---------------- sequence check ----------------
    logic [7:0]        s1_seq;
    logic [7:0]        s2_seq;
    logic [NUM_CH-1:0] exp_v;
    logic [7:0]        exp_s [NUM_CH];
    logic              unused_seq_lsb;

    assign unused_seq_lsb = ^rx_c_seq_id[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_seq <= '0;
            s2_seq <= '0;
        end else begin
            if (avst_sink_c_valid) begin
                s1_seq <= rx_c_seq_id[15:8];
            end
            s2_seq <= s1_seq;
        end
    end

    // Every matched PRACH message advances the expectation, whether or not
    // the FIFO had room for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_v         <= '0;
            seq_err_count <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                exp_s[k] <= '0;
            end
        end else if (stat_clr) begin
            exp_v         <= '0;
            seq_err_count <= '0;
        end else if (push_req) begin
            if (exp_v[s2_cmd.chan] && (exp_s[s2_cmd.chan] != s2_seq) &&
                (seq_err_count != 16'hFFFF)) begin
                seq_err_count <= seq_err_count + 16'd1;
            end
            exp_v[s2_cmd.chan] <= 1'b1;
            exp_s[s2_cmd.chan] <= s2_seq + 8'd1;
        end
    end
`else
    logic unused_seq;
    assign unused_seq = ^rx_c_seq_id;
`endif

endmodule

// File: tb/tb_prach_c_plane_mc.sv
`timescale 1ns/1ps
module tb_prach_c_plane_mc;

    localparam int NUM_CH = 24;
    localparam int CH_W   = 5;
    localparam int DEPTH  = 4;
    localparam int FILTER = 1;
    localparam int BIAS   = 864;

    typedef struct packed {
        logic [15:0] rtc;
        logic [15:0] seq;
        logic        dir;
        logic [2:0]  pv;
        logic [3:0]  filt;
        logic [7:0]  frame;
        logic [3:0]  sf;
        logic [5:0]  slot;
        logic [5:0]  sym;
        logic [7:0]  stype;
        logic [15:0] toff;
        logic [15:0] cp;
        logic [7:0]  udc;
        logic [11:0] sid;
        logic        rb;
        logic        si;
        logic [9:0]  sp;
        logic [7:0]  np;
        logic [3:0]  ns;
        logic [23:0] fo;
    } msg_t;

    typedef struct packed {
        logic [CH_W-1:0] chan;
        logic [16:0]     freq;
        logic [19:0]     tim;
        logic [3:0]      nsym;
        logic [119:0]    hdr;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic avst = 1'b0;
    msg_t drv = '0;
    logic cfg_we = 1'b0;
    logic [CH_W-1:0] cfg_addr = '0;
    logic cfg_en = 1'b0;
    logic [15:0] cfg_rtc = '0;
    logic stat_clr = 1'b0;
    logic m_ready = 1'b0;

    logic            m_valid;
    logic [CH_W-1:0] m_chan;
    logic [16:0]     m_frequency_offset;
    logic [19:0]     m_time_offset;
    logic [3:0]      m_num_symbol;
    logic [119:0]    m_header;
    logic [15:0]     drop_count;
    logic [15:0]     nomatch_count;
    logic            overflow;
`ifdef PRACH_C_PLANE_SEQ_CHECK_EN
    logic [15:0]     seq_err_count;
`endif

    always #5 clk = ~clk;

    prach_c_plane_mc dut (
        .clk                 (clk),
        .rst                 (rst),
        .avst_sink_c_valid   (avst),
        .rx_c_rtc_id         (drv.rtc),
        .rx_c_seq_id         (drv.seq),
        .rx_c_dataDirection  (drv.dir),
        .rx_c_payloadVersion (drv.pv),
        .rx_c_filterIndex    (drv.filt),
        .rx_c_frameId        (drv.frame),
        .rx_c_subframeId     (drv.sf),
        .rx_c_slotId         (drv.slot),
        .rx_c_symbolId       (drv.sym),
        .rx_c_sectionType    (drv.stype),
        .rx_c_timeOffset     (drv.toff),
        .rx_c_cpLength       (drv.cp),
        .rx_c_udCompHdr      (drv.udc),
        .rx_c_sectionId      (drv.sid),
        .rx_c_rb             (drv.rb),
        .rx_c_symInc         (drv.si),
        .rx_c_startPrbc      (drv.sp),
        .rx_c_numPrbc        (drv.np),
        .rx_c_numSymbol      (drv.ns),
        .rx_c_freqOffset     (drv.fo),
        .cfg_we              (cfg_we),
        .cfg_addr            (cfg_addr),
        .cfg_en              (cfg_en),
        .cfg_rtc_id          (cfg_rtc),
        .stat_clr            (stat_clr),
        .m_valid             (m_valid),
        .m_ready             (m_ready),
        .m_chan              (m_chan),
        .m_frequency_offset  (m_frequency_offset),
        .m_time_offset       (m_time_offset),
        .m_num_symbol        (m_num_symbol),
        .m_header            (m_header),
        .drop_count          (drop_count),
        .nomatch_count       (nomatch_count),
        .overflow            (overflow)
`ifdef PRACH_C_PLANE_SEQ_CHECK_EN
        ,
        .seq_err_count       (seq_err_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check_eq(input string nm, input logic [199:0] act,
                            input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] t_rtc [NUM_CH];
    bit          t_en  [NUM_CH];
    bit          m1_v;
    msg_t        m1;
    bit          m2_v;
    bit          m2_hit;
    cmd_t        m2_cmd;
    logic [7:0]  m2_seq;
    cmd_t        sb[$];
    int          occ;
    logic [15:0] mdrop, mnm, mseq;
    bit          movf;
    bit          exp_v [NUM_CH];
    logic [7:0]  exp_s [NUM_CH];

    function automatic logic [15:0] default_id(input int k);
        int cc, ant;
        cc  = k / 8;
        ant = k % 8;
        return {4'h0, 4'(ant / 4), 4'(cc), 4'(ant % 4)};
    endfunction

    function automatic cmd_t expect_cmd(input msg_t m, input int ch);
        cmd_t c;
        int f, t;
        f = -int'($signed(m.fo)) - BIAS;
        t = int'(m.sf) * 61440 + int'(m.sym) * 4384 + ((int'(m.sym) + 6) / 7) * 32
            + 2 * int'(m.toff) + 2 * int'(m.cp);
        c.chan = CH_W'(ch);
        c.freq = f[16:0];
        c.tim  = t[19:0];
        c.nsym = m.ns;
        c.hdr  = {16'b0, m.rtc, 16'b0, m.dir, m.pv, m.filt, m.frame, m.sf,
                  m.slot, m.sym, m.sid, m.rb, m.si, m.sp, m.np, m.udc};
        return c;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < NUM_CH; k++) begin
            t_rtc[k] = default_id(k);
            t_en[k]  = 1'b1;
            exp_v[k] = 1'b0;
            exp_s[k] = '0;
        end
        m1_v = 0; m1 = '0; m2_v = 0; m2_hit = 0; m2_cmd = '0; m2_seq = '0;
        sb.delete();
        occ = 0; mdrop = 0; mnm = 0; mseq = 0; movf = 0;
    endtask

    task automatic model_step();
        bit pop, drop_ev, nm_ev, se_ev;
        int ch;
        pop = (occ > 0) && m_ready;
        drop_ev = 0; nm_ev = 0; se_ev = 0;
        if (m2_v) begin
            if (m2_hit) begin
                if (exp_v[m2_cmd.chan] && (exp_s[m2_cmd.chan] != m2_seq)) se_ev = 1;
                if (occ < DEPTH || pop) begin
                    sb.push_back(m2_cmd);
                    occ++;
                end else begin
                    drop_ev = 1;
                end
            end else begin
                nm_ev = 1;
            end
        end
        if (pop) occ--;
        if (stat_clr) begin
            mdrop = 0; mnm = 0; movf = 0; mseq = 0;
            for (int k = 0; k < NUM_CH; k++) exp_v[k] = 1'b0;
        end else begin
            if (drop_ev) begin
                movf = 1;
                if (mdrop != 16'hFFFF) mdrop++;
            end
            if (nm_ev && mnm != 16'hFFFF) mnm++;
            if (se_ev && mseq != 16'hFFFF) mseq++;
            if (m2_v && m2_hit) begin
                exp_v[m2_cmd.chan] = 1'b1;
                exp_s[m2_cmd.chan] = m2_seq + 8'd1;
            end
        end
        // message waiting in stage 1 looks up the table before this edge's write
        m2_v   = m1_v && (m1.dir == 1'b0) && (m1.filt == 4'(FILTER)) && (m1.stype == 8'd3);
        m2_hit = 0;
        ch     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!m2_hit && t_en[k] && t_rtc[k] == m1.rtc) begin
                m2_hit = 1;
                ch     = k;
            end
        end
        m2_cmd = expect_cmd(m1, ch);
        m2_seq = m1.seq[15:8];
        if (cfg_we && int'(cfg_addr) < NUM_CH) begin
            t_rtc[cfg_addr] = cfg_rtc;
            t_en[cfg_addr]  = cfg_en;
        end
        m1_v = avst;
        if (avst) m1 = drv;
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) reset_model();
            else model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        cmd_t dut_c;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                dut_c = {m_chan, m_frequency_offset, m_time_offset, m_num_symbol, m_header};
                check_eq("m_valid", m_valid, occ > 0);
                if (occ > 0 && sb.size() > 0) begin
                    if (m_valid) check_eq("cmd", dut_c, sb[0]);
                    if (m_ready) void'(sb.pop_front());
                end
                check_eq("drop_count", drop_count, mdrop);
                check_eq("nomatch_count", nomatch_count, mnm);
                check_eq("overflow", overflow, movf);
`ifdef PRACH_C_PLANE_SEQ_CHECK_EN
                check_eq("seq_err_count", seq_err_count, mseq);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    int ready_pct = 90;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        avst = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input msg_t m);
        drv  = m;
        avst = 1'b1;
        step();
        avst = 1'b0;
    endtask

    function automatic logic [15:0] pick_rtc();
        int r;
        logic [15:0] pool [3];
        pool[0] = 16'hABCD; pool[1] = 16'h1234; pool[2] = 16'h0555;
        r = $urandom_range(0, 9);
        if (r < 5) return default_id($urandom_range(0, NUM_CH - 1));
        if (r < 7) return pool[$urandom_range(0, 2)];
        return 16'($urandom);
    endfunction

    function automatic msg_t rand_msg(input bit force_prach);
        logic [191:0] r;
        msg_t m;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        m = r[171:0];
        m.rtc = pick_rtc();
        if (force_prach || $urandom_range(0, 9) < 7) begin
            m.dir = 1'b0; m.filt = 4'(FILTER); m.stype = 8'd3;
        end
        return m;
    endfunction

    function automatic msg_t prach_msg(input logic [15:0] rtc);
        msg_t m;
        m = rand_msg(1'b1);
        m.rtc = rtc;
        return m;
    endfunction

    task automatic pulse_clr();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_valid) seen = 1;
        end
        check_eq(nm, seen, 1'b1);
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: ready_pct = 20;
                    1: ready_pct = 60;
                    default: ready_pct = 95;
                endcase
            end
            drv      = rand_msg(1'b0);
            avst     = ($urandom_range(0, 9) < 6);
            m_ready  = ($urandom_range(0, 99) < ready_pct);
            cfg_we   = ($urandom_range(0, 49) == 0);
            cfg_addr = CH_W'($urandom_range(0, 31));
            cfg_en   = ($urandom_range(0, 3) != 0);
            cfg_rtc  = pick_rtc();
            stat_clr = ($urandom_range(0, 199) == 0);
            step();
        end
        avst = 1'b0; cfg_we = 1'b0; stat_clr = 1'b0;
    endtask

    initial begin
        msg_t m;
        int tv;
        rst = 1'b1;
        repeat (3) step();
        check_eq("rst_m_valid", m_valid, 1'b0);
        check_eq("rst_m_chan", m_chan, 0);
        check_eq("rst_m_freq", m_frequency_offset, 0);
        check_eq("rst_m_time", m_time_offset, 0);
        check_eq("rst_m_nsym", m_num_symbol, 0);
        check_eq("rst_m_header", m_header, 0);
        check_eq("rst_drop", drop_count, 0);
        check_eq("rst_nomatch", nomatch_count, 0);
        check_eq("rst_overflow", overflow, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        // directed: single PRACH message through an empty FIFO
        m_ready = 1'b1;
        m = prach_msg(16'h0112);
        m.sf = 4'd2; m.sym = 6'd7; m.toff = 16'd100; m.cp = 16'd50;
        m.fo = 24'(-1000);
        send(m);
        wait_valid("t1_wait_valid");
        tv = 2 * 61440 + 7 * 4384 + ((7 + 6) / 7) * 32 + 2 * 100 + 2 * 50;
        check_eq("t1_chan", m_chan, 14);
        check_eq("t1_freq", m_frequency_offset, 17'd136);
        check_eq("t1_time", m_time_offset, 20'(tv));
        idle(3);

        // directed: non-PRACH ignored, unmatched PRACH counted
        m = prach_msg(16'h0112); m.stype = 8'd1; send(m);
        m = prach_msg(16'h0112); m.dir = 1'b1; send(m);
        m = prach_msg(16'h0112); m.filt = 4'd0; send(m);
        idle(4);
        check_eq("t2_nomatch0", nomatch_count, 0);
        send(prach_msg(16'h0555));
        idle(4);
        check_eq("t2_nomatch1", nomatch_count, 1);

        // directed: table reprogramming
        cfg_we = 1'b1; cfg_addr = 5'd5; cfg_en = 1'b1; cfg_rtc = 16'hABCD;
        step();
        cfg_we = 1'b0;
        send(prach_msg(16'hABCD));
        wait_valid("t3_wait_valid");
        check_eq("t3_chan", m_chan, 5);
        idle(3);
        send(prach_msg(16'h0101));
        idle(4);
        check_eq("t3_nomatch", nomatch_count, 2);

        // directed: overflow with consumer stalled
        pulse_clr();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(prach_msg(default_id(8 + i)));
        idle(4);
        check_eq("t4_drop", drop_count, 2);
        check_eq("t4_overflow", overflow, 1);
        m_ready = 1'b1;
        idle(6);
        pulse_clr();
        idle(1);
        check_eq("t4_clr_drop", drop_count, 0);
        check_eq("t4_clr_nomatch", nomatch_count, 0);
        check_eq("t4_clr_overflow", overflow, 0);

        // directed: full FIFO with a pop in the push cycle
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(prach_msg(default_id(16 + i)));
        idle(3);
        send(prach_msg(default_id(20)));
        idle(1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        idle(2);
        check_eq("t5_drop", drop_count, 0);
        check_eq("t5_valid", m_valid, 1);
        m_ready = 1'b1;
        idle(6);

`ifdef PRACH_C_PLANE_SEQ_CHECK_EN
        pulse_clr();
        m = prach_msg(16'h0000); m.seq[15:8] = 8'd3; send(m);
        m = prach_msg(16'h0000); m.seq[15:8] = 8'd4; send(m);
        m = prach_msg(16'h0000); m.seq[15:8] = 8'd6; send(m);
        idle(6);
        check_eq("t6_seq_err", seq_err_count, 1);
`endif

        // randomized traffic, mid-operation reset, more traffic
        rand_phase(2500);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_msg(1'b1));
        rst = 1'b1;
        step();
        step();
        check_eq("midrst_valid", m_valid, 0);
        rst = 1'b0;
        rand_phase(1500);

        m_ready = 1'b1;
        idle(4);
        for (int i = 0; i < 20 && occ > 0; i++) step();
        @(negedge clk);
        check_eq("drain_valid", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
